// File: rtl/data_table_rd_arbiter.sv
// Round-robin arbiter sharing the data-table RAM read port among search engines,
// with a tag pipeline that routes returning data to its requester. Option: DT_RD_ARB_STALL_CNT_EN.
module data_table_rd_arbiter #(
  parameter int REQ_CNT     = 3,
  parameter int A_WIDTH     = 10,
  parameter int D_WIDTH     = 64,
  parameter int RAM_LATENCY = 2,
  localparam int ID_WIDTH   = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [REQ_CNT-1:0]         req_i,
  input  logic [REQ_CNT*A_WIDTH-1:0] req_addr_i,
  output logic [REQ_CNT-1:0]         gnt_o,
  output logic [REQ_CNT-1:0]         rd_data_val_o,
  output logic [D_WIDTH-1:0]         rd_data_o,
  output logic [A_WIDTH-1:0]         ram_rd_addr_o,
  output logic                       ram_rd_en_o,
  input  logic [D_WIDTH-1:0]         ram_rd_data_i,
  output logic                       busy_o,
  output logic [15:0]                stall_cnt_o
);

  // Handshake: req_i is held with a stable address until gnt_o is seen high in
  // the same cycle; a grant issues the read and the data returns RAM_LATENCY
  // cycles later, flagged by rd_data_val_o for that requester only.

  logic [ID_WIDTH-1:0]    ptr_q;
  logic                   win_vld;
  int                     win_idx;
  int                     cand;
  logic [ID_WIDTH-1:0]    win_id;

  logic [RAM_LATENCY-1:0] vld_q;
  logic [ID_WIDTH-1:0]    id_q [RAM_LATENCY];

  always_comb begin
    win_vld = 1'b0;
    win_idx = 0;
    cand    = 0;
    for (int k = 0; k < REQ_CNT; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= REQ_CNT) cand = cand - REQ_CNT;
      if (!win_vld && req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_id        = ID_WIDTH'(win_idx);
  assign gnt_o         = win_vld ? (REQ_CNT'(1) << win_idx) : '0;
  assign ram_rd_en_o   = win_vld;
  assign ram_rd_addr_o = win_vld ? req_addr_i[win_idx*A_WIDTH +: A_WIDTH] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (win_vld) begin
      ptr_q <= (win_idx == REQ_CNT-1) ? '0 : ID_WIDTH'(win_idx + 1);
    end
  end

  // Tag pipeline never stalls: it mirrors the fixed RAM read latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) id_q[i] <= '0;
    end else begin
      vld_q[0] <= win_vld;
      id_q[0]  <= win_id;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign rd_data_val_o = vld_q[RAM_LATENCY-1] ? (REQ_CNT'(1) << id_q[RAM_LATENCY-1]) : '0;
  assign rd_data_o     = ram_rd_data_i;
  assign busy_o        = |vld_q;

`ifdef DT_RD_ARB_STALL_CNT_EN
  logic [15:0] stall_q;
  logic [4:0]  lost;
  logic [16:0] stall_sum;

  always_comb begin
    lost = '0;
    for (int i = 0; i < REQ_CNT; i++) lost = lost + 5'(req_i[i] & ~gnt_o[i]);
  end

  assign stall_sum = {1'b0, stall_q} + 17'(lost);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_data_table_rd_arbiter.sv
// Bench for data_table_rd_arbiter: directed and random request traffic against a
// grant-history reference model, plus a REQ_CNT=1 / RAM_LATENCY=1 instance.
module tb_data_table_rd_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int L  = 2;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [N-1:0]    req_i = '0;
  logic [AW-1:0]   tb_addr [N];
  logic [N*AW-1:0] req_addr_i;
  logic [N-1:0]    gnt_o, rd_data_val_o;
  logic [DW-1:0]   rd_data_o, ram_rd_data_i;
  logic [AW-1:0]   ram_rd_addr_o;
  logic            ram_rd_en_o, busy_o;
  logic [15:0]     stall_cnt_o;

  assign req_addr_i = {tb_addr[2], tb_addr[1], tb_addr[0]};

  data_table_rd_arbiter #(.REQ_CNT(N), .A_WIDTH(AW), .D_WIDTH(DW), .RAM_LATENCY(L)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_addr_i(req_addr_i),
    .gnt_o(gnt_o), .rd_data_val_o(rd_data_val_o), .rd_data_o(rd_data_o),
    .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_en_o(ram_rd_en_o),
    .ram_rd_data_i(ram_rd_data_i), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  logic          d_req = 1'b0;
  logic          d_gnt, d_val, d_en, d_busy;
  logic [DW-1:0] d_data;
  logic [AW-1:0] d_addr_o;
  logic [15:0]   d_stall;
  localparam logic [DW-1:0] D_RAM  = 64'hFEED_0000_1234_5678;
  localparam logic [AW-1:0] D_ADDR = 8'h33;

  data_table_rd_arbiter #(.REQ_CNT(1), .A_WIDTH(AW), .D_WIDTH(DW), .RAM_LATENCY(1)) dut_deg (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(d_req), .req_addr_i(D_ADDR),
    .gnt_o(d_gnt), .rd_data_val_o(d_val), .rd_data_o(d_data),
    .ram_rd_addr_o(d_addr_o), .ram_rd_en_o(d_en),
    .ram_rd_data_i(D_RAM), .busy_o(d_busy), .stall_cnt_o(d_stall)
  );

  // RAM model: word content is a function of address, delivered L cycles later
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {8{a}} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  logic [DW-1:0] rp [L];
  always @(posedge clk_i) begin
    rp[0] <= ram_word(ram_rd_addr_o);
    for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
  end
  assign ram_rd_data_i = rp[L-1];

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];
  int hist [0:4095];
  int cyc    = 0;
  int m_ptr  = 0;
  int m_stall = 0;
  int last_w = -1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, act, exp);
    end
  endtask

  // one clock cycle: check at negedge, advance the model, return at posedge+1
  task automatic run_cycle();
    int w;
    int idx;
    logic [N-1:0]  eg, ev;
    logic [AW-1:0] ea;
    logic          eb;
    logic [11:0]   e;
    @(negedge clk_i);
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (w < 0 && req_i[idx]) w = idx;
    end
    eg = (w >= 0) ? N'(1 << w) : '0;
    ea = (w >= 0) ? tb_addr[w] : '0;
    check_eq("gnt", gnt_o, eg);
    check_eq("rd_en", ram_rd_en_o, (w >= 0));
    check_eq("rd_addr", ram_rd_addr_o, ea);
    ev = '0;
    if (cyc >= L && hist[cyc-L] >= 0) ev = N'(1 << hist[cyc-L]);
    check_eq("rd_val", rd_data_val_o, ev);
    if (ev != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("ret_queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("ret_id", e[11:8], hist[cyc-L]);
        check_eq("rd_data", rd_data_o, ram_word(e[7:0]));
      end
    end
    eb = 1'b0;
    for (int j = 1; j <= L; j++) if (cyc - j >= 0 && hist[cyc-j] >= 0) eb = 1'b1;
    check_eq("busy", busy_o, eb);
`ifdef DT_RD_ARB_STALL_CNT_EN
    check_eq("stall", stall_cnt_o, m_stall);
`else
    check_eq("stall", stall_cnt_o, 0);
`endif
    if (rst_i) begin
      hist[cyc] = -1;
      last_w = -1;
    end else begin
      hist[cyc] = w;
      last_w = w;
      if (w >= 0) begin
        exp_q.push_back({4'(w), ea});
        m_ptr = (w == N-1) ? 0 : w + 1;
      end
      m_stall = m_stall + $countones(req_i & ~eg);
      if (m_stall > 16'hFFFF) m_stall = 16'hFFFF;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    req_i = '0;
    last_w = -1;
    for (int j = 0; j < cyc; j++) hist[j] = -1;
    exp_q.delete();
    m_ptr = 0;
    m_stall = 0;
    repeat (n) run_cycle();
    rst_i = 1'b0;
  endtask

  // requesters hold until granted, then drop or issue a fresh address
  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && last_w == i) begin
        req_i[i] = 1'($urandom_range(0, 1));
        if (req_i[i]) tb_addr[i] = AW'($urandom);
      end else if (!req_i[i] && $urandom_range(0, 2) == 0) begin
        req_i[i] = 1'b1;
        tb_addr[i] = AW'($urandom);
      end
    end
  endtask

  int pulses;

  initial begin
    for (int i = 0; i < 4096; i++) hist[i] = -1;
    for (int i = 0; i < N; i++) tb_addr[i] = '0;
    do_reset(2);

    // full contention from ptr 0
    tb_addr[0] = 8'h01; tb_addr[1] = 8'h02; tb_addr[2] = 8'h03;
    req_i = 3'b111;
    repeat (6) run_cycle();
    req_i = '0;
    repeat (3) run_cycle();

    // single request, then wrap-around
    do_reset(1);
    tb_addr[1] = 8'h15;
    req_i = 3'b010;
    run_cycle();
    req_i = '0;
    repeat (3) run_cycle();
    tb_addr[2] = 8'h2A;
    req_i = 3'b100;
    run_cycle();
    tb_addr[0] = 8'h40; tb_addr[2] = 8'h42;
    req_i = 3'b101;
    run_cycle();
    req_i = 3'b100;
    run_cycle();

    // idle after a grant
    req_i = '0;
    repeat (5) run_cycle();

    // reset while a read is in flight
    tb_addr[0] = 8'h44;
    req_i = 3'b001;
    run_cycle();
    req_i = '0;
    run_cycle();
    do_reset(3);
    req_i = 3'b111;
    run_cycle();
    req_i = '0;
    repeat (3) run_cycle();

    // random traffic
    for (int n = 0; n < 500; n++) begin
      run_cycle();
      drive_random();
    end
    req_i = '0;
    repeat (L + 2) run_cycle();
    check_eq("drain", exp_q.size(), 0);

    // degenerate single-requester build
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      d_req = (k < 4);
      @(negedge clk_i);
      check_eq("deg_gnt", d_gnt, (k < 4));
      check_eq("deg_en", d_en, (k < 4));
      if (k < 4) check_eq("deg_addr", d_addr_o, D_ADDR);
      check_eq("deg_val", d_val, (k >= 1 && k <= 4));
      if (d_val) begin
        pulses++;
        check_eq("deg_data", d_data, D_RAM);
      end
      @(posedge clk_i);
      #1;
    end
    check_eq("deg_pulses", pulses, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_table_rd_arbiter.md
Name: data_table_rd_arbiter

Overview:
- Round-robin arbiter that shares the single data-table RAM read port among REQ_CNT search engines.
- Replaces the fixed rotating read-slot scheme and the priority address mux.
- Grants at most one read per cycle and drives the RAM address and enable.
- Tracks each issued read through a RAM_LATENCY-deep tag pipeline, so that returning data is flagged only to the requester that issued it.

Parameters:
REQ_CNT, 3, number of requesters (search engines); legal range 1..16
A_WIDTH, TABLE_ADDR_WIDTH, data-table address width
D_WIDTH, 64, data-table read-data width
RAM_LATENCY, 2, cycles from rd_en to valid rd_data; legal range 1..8
ID_WIDTH, (REQ_CNT>1 ? $clog2(REQ_CNT) : 1), requester tag width (derived, not overridden)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
req_i  input  REQ_CNT  per-requester read request; held until granted
req_addr_i  input  REQ_CNT*A_WIDTH  per-requester address; requester i uses bits [i*A_WIDTH +: A_WIDTH]
gnt_o  output  REQ_CNT  one-hot grant; combinational, same cycle as the request
rd_data_val_o  output  REQ_CNT  one-hot, registered; data for this requester is on rd_data_o
rd_data_o  output  D_WIDTH  broadcast read data (ram_rd_data_i passed through)
ram_rd_addr_o  output  A_WIDTH  RAM read address
ram_rd_en_o  output  1  RAM read enable
ram_rd_data_i  input  D_WIDTH  RAM read data
busy_o  output  1  at least one read in flight
stall_cnt_o  output  16  requester-cycles lost to arbitration (optional feature)

Behaviour:
Reset values:
- ptr=0, tag pipeline cleared.
- rd_data_val_o=0, busy_o=0, stall_cnt_o=0.
- gnt_o=0 and ram_rd_en_o=0 while req_i=0.

Arbitration (combinational):
- Search requesters starting at ptr in the order ptr, ptr+1, …, REQ_CNT-1, 0, …, ptr-1.
- The first requester found with req_i set is the winner w.
- gnt_o[w]=1 and ram_rd_en_o=1; ram_rd_addr_o = that requester's address slice.
- With no request: ram_rd_addr_o=0 and ram_rd_en_o=0.
- A request whose gnt_o is low has not been issued; the requester must keep req_i and its address stable.

Pointer update:
- On a grant, ptr <= (w==REQ_CNT-1) ? 0 : w+1. Wrap is explicit.
- No grant: ptr holds.
- Every continuously requesting engine is served within REQ_CNT cycles.

Tag pipeline:
- Shift register of RAM_LATENCY stages, each stage {vld, id}.
- Stage 0 <= {ram_rd_en_o, w} every cycle; stages shift every cycle and never stall.
- rd_data_val_o[id] = last-stage vld, decoded one-hot. It asserts exactly RAM_LATENCY cycles after the grant cycle.
- rd_data_o = ram_rd_data_i, combinational.
- Back-to-back grants produce back-to-back returns in grant order.

busy_o:
- OR of all stage vld bits. Low only when no read is outstanding.

REQ_CNT=1:
- ptr is constant 0.
- gnt_o = req_i.
- Tag id is always 0.

Reset mid-operation:
- The pipeline is cleared asynchronously. In-flight reads are dropped and no rd_data_val_o is produced for them.
- Requesters are reset by the same rst_i.

Optional Feature:
Macro DT_RD_ARB_STALL_CNT_EN:
- Defined:
  - Each cycle, stall_cnt_o increments by popcount(req_i & ~gnt_o).
  - The counter saturates at 16'hFFFF and resets to 0.
- Not defined:
  - stall_cnt_o is tied to 0 and no counter logic is built.

Test Plan:
1. Single request: REQ_CNT=3, RAM_LATENCY=2; req_i=3'b010 with addr 0x15 for one cycle. Required: gnt_o=3'b010, ram_rd_addr_o=0x15 in the same cycle; rd_data_val_o=3'b010 exactly 2 cycles later with rd_data_o equal to the RAM model's word 0x15.
2. Full contention: req_i=3'b111 held, ptr=0. Required: grants 001, 010, 100, 001… on consecutive cycles; returns appear in the same order 2 cycles behind; with the macro defined, stall_cnt_o increases by 2 per cycle.
3. Wrap-around: grant to requester 2, then req_i=3'b101. Required: requester 0 is granted next (ptr wrapped to 0), then requester 2.
4. Idle and busy: no requests for 5 cycles after one grant. Required: busy_o=1 for exactly RAM_LATENCY cycles, then 0; ptr is unchanged while idle.
5. Reset mid-flight: assert rst_i 1 cycle after a grant. Required: rd_data_val_o stays 0, busy_o=0, and after release the first grant goes to requester 0.
6. Degenerate build: REQ_CNT=1, RAM_LATENCY=1; req_i held for 4 cycles. Required: 4 grants and 4 consecutive rd_data_val_o pulses, each 1 cycle after its grant.
